fetch_ctrl: RTL and testbench

Sequencer for the instruction-fetch stage: picks the next-PC source, stalls fetch, and schedules interrupt and exception vectoring. It feeds the fetch stage's `PC_IF_ID_Write`, `select_PC_next` and `status` inputs. Redirect requests come from the ID and EX stages. It also tracks user/kernel mode, so interrupts are masked while a handler runs.

---
 rtl/fetch_ctrl.sv | 159 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer. Chooses the next-PC source,
//               stalls the PC / IF_ID update, and schedules interrupt and
//               exception vectoring. Also tracks the user/kernel mode so that
//               interrupts stay masked while a handler runs.
//
// Ports
//   clk             in   clock
//   rst_n           in   asynchronous active-low reset
//   branch_taken    in   EX-stage branch resolved taken (flushes ID)
//   jump            in   ID holds a j
//   jr              in   ID holds a jr
//   eret            in   ID holds a return-from-handler (always with jr)
//   exception       in   ID holds an undefined / faulting instruction
//   load_use_hazard in   ID must stall one cycle
//   irq             in   external interrupt, level-sensitive
//   PC_IF_ID_Write  out  enables the PC and IF_ID register update
//   select_PC_next  out  one-hot {branch, j, jr}, or 000
//   status          out  {interrupt, exception}; nonzero only when select=000
//   irq_ack         out  one-cycle pulse when the interrupt vector is issued
//   mode            out  USER=00, KERNEL=01, RETURN=10
//
// Build option
//   FETCH_CTRL_IRQ_SYNC_EN : when defined, irq passes through a two-flop
//                            synchronizer before edge detection.
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       branch_taken,
  input  logic       jump,
  input  logic       jr,
  input  logic       eret,
  input  logic       exception,
  input  logic       load_use_hazard,
  input  logic       irq,
  output logic       PC_IF_ID_Write,
  output logic [2:0] select_PC_next,
  output logic [1:0] status,
  output logic       irq_ack,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    MODE_USER   = 2'b00,
    MODE_KERNEL = 2'b01,
    MODE_RETURN = 2'b10
  } mode_e;

  localparam logic [2:0] c_SEL_NONE   = 3'b000;
  localparam logic [2:0] c_SEL_BRANCH = 3'b100;
  localparam logic [2:0] c_SEL_J      = 3'b010;
  localparam logic [2:0] c_SEL_JR     = 3'b001;

  localparam logic [1:0] c_ST_NONE = 2'b00;
  localparam logic [1:0] c_ST_EXC  = 2'b01;
  localparam logic [1:0] c_ST_IRQ  = 2'b10;

  // Kept as a plain 2-bit vector so the unused 11 encoding is representable
  // and recoverable.
  logic [1:0] r_mode;
  logic [1:0] w_mode_next;
  logic       r_irq_pending;
  logic       r_irq_prev;
  logic       w_irq_int;
  logic       w_irq_rise;

  // --------------------------------------------------------------------------
  // Interrupt input conditioning
  // --------------------------------------------------------------------------
`ifdef FETCH_CTRL_IRQ_SYNC_EN
  logic [1:0] r_irq_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_sync <= 2'b00;
    end else begin
      r_irq_sync <= {r_irq_sync[0], irq};
    end
  end

  assign w_irq_int = r_irq_sync[1];
`else
  assign w_irq_int = irq;
`endif

  // The previous-sample flop resets high: a level that is already asserted
  // when reset lifts is not an edge; it must fall and rise again.
  assign w_irq_rise = w_irq_int & ~r_irq_prev;

  // --------------------------------------------------------------------------
  // Per-cycle decision (first match wins)
  // --------------------------------------------------------------------------
  always_comb begin
    PC_IF_ID_Write = 1'b1;
    select_PC_next = c_SEL_NONE;
    status         = c_ST_NONE;
    irq_ack        = 1'b0;

    // Baseline next state: RETURN is a one-cycle guard, the unused encoding
    // falls back to USER, USER/KERNEL hold.
    case (r_mode)
      MODE_USER:   w_mode_next = MODE_USER;
      MODE_KERNEL: w_mode_next = MODE_KERNEL;
      MODE_RETURN: w_mode_next = MODE_USER;
      default:     w_mode_next = MODE_USER;
    endcase

    if (branch_taken) begin
      // ID is flushed, so every ID-stage request (and the stall) is dropped.
      select_PC_next = c_SEL_BRANCH;
    end else if (load_use_hazard) begin
      // ID requests are re-presented next cycle; hold the RETURN guard too.
      PC_IF_ID_Write = 1'b0;
      if (r_mode == MODE_RETURN) begin
        w_mode_next = MODE_RETURN;
      end
    end else if (exception) begin
      status      = c_ST_EXC;
      w_mode_next = MODE_KERNEL;
    end else if (jr) begin
      select_PC_next = c_SEL_JR;
      // eret outside KERNEL is just a jr.
      if (eret && (r_mode == MODE_KERNEL)) begin
        w_mode_next = MODE_RETURN;
      end
    end else if (jump) begin
      select_PC_next = c_SEL_J;
    end else if ((r_mode == MODE_USER) && r_irq_pending) begin
      status      = c_ST_IRQ;
      irq_ack     = 1'b1;
      w_mode_next = MODE_KERNEL;
    end
  end

  assign mode = r_mode;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode        <= MODE_USER;
      r_irq_pending <= 1'b0;
      r_irq_prev    <= 1'b1;
    end else begin
      r_mode        <= w_mode_next;
      r_irq_prev    <= w_irq_int;
      // A new edge in the same cycle as the ack wins over the clear.
      r_irq_pending <= w_irq_rise | (r_irq_pending & ~irq_ack);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl. Each scenario task queues
//               stimulus rows with their expected outputs; the expectation is
//               pushed to a scoreboard when the row is driven and popped when
//               the outputs are sampled mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       branch_taken = 1'b0;
  logic       jump = 1'b0;
  logic       jr = 1'b0;
  logic       eret = 1'b0;
  logic       exception = 1'b0;
  logic       load_use_hazard = 1'b0;
  logic       irq = 1'b0;
  logic       PC_IF_ID_Write;
  logic [2:0] select_PC_next;
  logic [1:0] status;
  logic       irq_ack;
  logic [1:0] mode;

  fetch_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .branch_taken    (branch_taken),
    .jump            (jump),
    .jr              (jr),
    .eret            (eret),
    .exception       (exception),
    .load_use_hazard (load_use_hazard),
    .irq             (irq),
    .PC_IF_ID_Write  (PC_IF_ID_Write),
    .select_PC_next  (select_PC_next),
    .status          (status),
    .irq_ack         (irq_ack),
    .mode            (mode)
  );

  always #5 clk = ~clk;

  // Cycles from the first cycle irq is high to the cycle irq_pending is seen.
`ifdef FETCH_CTRL_IRQ_SYNC_EN
  localparam int c_IRQ_LAT = 3;
`else
  localparam int c_IRQ_LAT = 1;
`endif

  // Stimulus bits: {branch_taken, jump, jr, eret, exception, load_use, irq}
  localparam logic [6:0] S_IDLE = 7'b0000000;
  localparam logic [6:0] S_BR   = 7'b1000000;
  localparam logic [6:0] S_J    = 7'b0100000;
  localparam logic [6:0] S_JR   = 7'b0010000;
  localparam logic [6:0] S_ERET = 7'b0001000;
  localparam logic [6:0] S_EXC  = 7'b0000100;
  localparam logic [6:0] S_LU   = 7'b0000010;
  localparam logic [6:0] S_IRQ  = 7'b0000001;

  localparam logic [1:0] M_U = 2'b00;
  localparam logic [1:0] M_K = 2'b01;
  localparam logic [1:0] M_R = 2'b10;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_q  [$];
  logic [6:0] stim_q [$];
  logic [8:0] plan_q [$];

  // Expected output vector {write, select, status, irq_ack, mode}
  function automatic logic [8:0] ev(input logic w, input logic [2:0] sel,
                                    input logic [1:0] st, input logic ack,
                                    input logic [1:0] md);
    return {w, sel, st, ack, md};
  endfunction

  function automatic logic [8:0] idle(input logic [1:0] md);
    return ev(1'b1, 3'b000, 2'b00, 1'b0, md);
  endfunction

  function automatic logic [8:0] sample();
    return {PC_IF_ID_Write, select_PC_next, status, irq_ack, mode};
  endfunction

  task automatic add(input logic [6:0] s, input logic [8:0] e);
    stim_q.push_back(s);
    plan_q.push_back(e);
  endtask

  task automatic run_cycle(input logic [6:0] s, output logic [8:0] obs);
    @(negedge clk);
    {branch_taken, jump, jr, eret, exception, load_use_hazard, irq} = s;
    #2;
    obs = sample();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {branch_taken, jump, jr, eret, exception, load_use_hazard, irq} = S_IDLE;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [8:0] obs, expd;
    logic [6:0] s;
    int i;
    // Reset held with irq high.
    add(S_IRQ, idle(M_U));
    add(S_IRQ, idle(M_U));
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      exp_q.push_back(plan_q.pop_front());
      run_cycle(s, obs);
      expd = exp_q.pop_front();
      n_checks++;
      if (obs !== expd) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %b, expected %b", i, obs, expd);
      end
      i++;
    end
    rst_n = 1'b1;
    // irq held across reset release must not be taken as an edge.
    for (int k = 0; k < 3; k++) begin
`ifdef FETCH_CTRL_IRQ_SYNC_EN
      add(S_IDLE, idle(M_U));
`else
      add(S_IRQ, idle(M_U));
`endif
    end
    add(S_IDLE, idle(M_U));
    for (int k = 0; k < c_IRQ_LAT; k++) add(S_IRQ, idle(M_U));
    add(S_IRQ, ev(1'b1, 3'b000, 2'b10, 1'b1, M_U));
    add(S_IRQ, idle(M_K));
    add(S_IDLE, idle(M_K));
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      exp_q.push_back(plan_q.pop_front());
      run_cycle(s, obs);
      expd = exp_q.pop_front();
      n_checks++;
      if (obs !== expd) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: got %b, expected %b", i, obs, expd);
      end
      i++;
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_branch_stall();
    logic [8:0] obs, expd;
    logic [6:0] s;
    int i;
    do_reset();
    add(S_BR | S_LU, ev(1'b1, 3'b100, 2'b00, 1'b0, M_U));
    add(S_LU,        ev(1'b0, 3'b000, 2'b00, 1'b0, M_U));
    add(S_LU | S_J,  ev(1'b0, 3'b000, 2'b00, 1'b0, M_U));
    add(S_J,         ev(1'b1, 3'b010, 2'b00, 1'b0, M_U));
    add(S_JR,        ev(1'b1, 3'b001, 2'b00, 1'b0, M_U));
    add(S_J | S_JR,  ev(1'b1, 3'b001, 2'b00, 1'b0, M_U));
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      exp_q.push_back(plan_q.pop_front());
      run_cycle(s, obs);
      expd = exp_q.pop_front();
      n_checks++;
      if (obs !== expd) begin
        n_fail++;
        $display("FAIL branch_stall[%0d]: got %b, expected %b", i, obs, expd);
      end
      i++;
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_kernel_return();
    logic [8:0] obs, expd;
    logic [6:0] s;
    int i;
    do_reset();
    add(S_EXC, ev(1'b1, 3'b000, 2'b01, 1'b0, M_U));
    add(S_IRQ, idle(M_K));
    for (int k = 0; k < c_IRQ_LAT; k++) add(S_IDLE, idle(M_K));
    add(S_EXC, ev(1'b1, 3'b000, 2'b01, 1'b0, M_K));
    add(S_JR | S_ERET, ev(1'b1, 3'b001, 2'b00, 1'b0, M_K));
    add(S_IDLE, idle(M_R));
    add(S_IDLE, ev(1'b1, 3'b000, 2'b10, 1'b1, M_U));
    add(S_IDLE, idle(M_K));
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      exp_q.push_back(plan_q.pop_front());
      run_cycle(s, obs);
      expd = exp_q.pop_front();
      n_checks++;
      if (obs !== expd) begin
        n_fail++;
        $display("FAIL kernel_return[%0d]: got %b, expected %b", i, obs, expd);
      end
      i++;
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_priority();
    logic [8:0] obs, expd;
    logic [6:0] s;
    int i;
    do_reset();
    add(S_IRQ, idle(M_U));
    for (int k = 1; k < c_IRQ_LAT; k++) add(S_IDLE, idle(M_U));
    add(S_BR | S_EXC | S_J, ev(1'b1, 3'b100, 2'b00, 1'b0, M_U));
    add(S_LU, ev(1'b0, 3'b000, 2'b00, 1'b0, M_U));
    add(S_IDLE, ev(1'b1, 3'b000, 2'b10, 1'b1, M_U));
    add(S_IDLE, idle(M_K));
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      exp_q.push_back(plan_q.pop_front());
      run_cycle(s, obs);
      expd = exp_q.pop_front();
      n_checks++;
      if (obs !== expd) begin
        n_fail++;
        $display("FAIL priority[%0d]: got %b, expected %b", i, obs, expd);
      end
      i++;
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_return_guard();
    logic [8:0] obs, expd;
    logic [6:0] s;
    int i;
    do_reset();
    add(S_EXC, ev(1'b1, 3'b000, 2'b01, 1'b0, M_U));
    add(S_JR | S_ERET, ev(1'b1, 3'b001, 2'b00, 1'b0, M_K));
    add(S_LU, ev(1'b0, 3'b000, 2'b00, 1'b0, M_R));
    add(S_BR, ev(1'b1, 3'b100, 2'b00, 1'b0, M_R));
    add(S_JR | S_ERET, ev(1'b1, 3'b001, 2'b00, 1'b0, M_U));
    add(S_IDLE, idle(M_U));
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      exp_q.push_back(plan_q.pop_front());
      run_cycle(s, obs);
      expd = exp_q.pop_front();
      n_checks++;
      if (obs !== expd) begin
        n_fail++;
        $display("FAIL return_guard[%0d]: got %b, expected %b", i, obs, expd);
      end
      i++;
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_illegal_state();
    logic [8:0] obs, expd;
    do_reset();
    @(negedge clk);
    force dut.r_mode = 2'b11;
    exp_q.push_back(ev(1'b1, 3'b000, 2'b00, 1'b0, 2'b11));
    #2;
    obs = sample();
    release dut.r_mode;
    expd = exp_q.pop_front();
    n_checks++;
    if (obs !== expd) begin
      n_fail++;
      $display("FAIL illegal_state_outputs: got %b, expected %b", obs, expd);
    end
    exp_q.push_back(idle(M_U));
    run_cycle(S_IDLE, obs);
    expd = exp_q.pop_front();
    n_checks++;
    if (obs !== expd) begin
      n_fail++;
      $display("FAIL illegal_state_recover: got %b, expected %b", obs, expd);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_async_reset();
    logic [8:0] obs, expd;
    logic [6:0] s;
    int i;
    do_reset();
    add(S_EXC, ev(1'b1, 3'b000, 2'b01, 1'b0, M_U));
    add(S_IRQ, idle(M_K));
    for (int k = 0; k < c_IRQ_LAT; k++) add(S_IDLE, idle(M_K));
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      exp_q.push_back(plan_q.pop_front());
      run_cycle(s, obs);
      expd = exp_q.pop_front();
      n_checks++;
      if (obs !== expd) begin
        n_fail++;
        $display("FAIL async_setup[%0d]: got %b, expected %b", i, obs, expd);
      end
      i++;
    end
    // Reset asserted between clock edges takes effect immediately.
    @(negedge clk);
    #3 rst_n = 1'b0;
    exp_q.push_back(idle(M_U));
    #1 obs = sample();
    expd = exp_q.pop_front();
    n_checks++;
    if (obs !== expd) begin
      n_fail++;
      $display("FAIL async_reset_now: got %b, expected %b", obs, expd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // The pending interrupt must have been dropped.
    for (int k = 0; k < c_IRQ_LAT + 2; k++) add(S_IDLE, idle(M_U));
    i = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      exp_q.push_back(plan_q.pop_front());
      run_cycle(s, obs);
      expd = exp_q.pop_front();
      n_checks++;
      if (obs !== expd) begin
        n_fail++;
        $display("FAIL async_dropped[%0d]: got %b, expected %b", i, obs, expd);
      end
      i++;
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    irq   = 1'b1;
    test_reset();
    test_branch_stall();
    test_kernel_return();
    test_priority();
    test_return_guard();
    test_illegal_state();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
